// File: rtl/light_sequencer_pkg.sv
// Shared encodings and defaults for the turn-signal / interior-light sequencer.
package light_sequencer_pkg;

  localparam logic [1:0] ExtOff    = 2'b00;
  localparam logic [1:0] ExtRight  = 2'b01;
  localparam logic [1:0] ExtLeft   = 2'b10;
  localparam logic [1:0] ExtHazard = 2'b11;

  // 2'b10 and 2'b11 both mean interior OFF
  localparam logic [1:0] IntOn   = 2'b00;
  localparam logic [1:0] IntDoor = 2'b01;
  localparam logic [1:0] IntOff  = 2'b10;

  localparam int unsigned DefaultBlinkHalf = 4;
  localparam int unsigned DefaultDomeHold  = 8;

  // Hazard wins; a single stalk picks its side; both stalks cancel out.
  function automatic logic [1:0] ext_next(input logic hazard, input logic left,
                                          input logic right);
    if (hazard) begin
      return ExtHazard;
    end else if (left ^ right) begin
      return left ? ExtLeft : ExtRight;
    end else begin
      return ExtOff;
    end
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Flash phase counter: counts 0..2*BLINK_HALF-1, restarting on request.
module blink_timer
  import light_sequencer_pkg::*;
#(
  parameter int unsigned BLINK_HALF = DefaultBlinkHalf
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic phase
);

  localparam logic [8:0] Half = 9'(BLINK_HALF);
  localparam logic [8:0] Last = 9'(2 * BLINK_HALF - 1);

  logic [8:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 9'd1;
    if (restart || !enable || (count_q == Last)) begin
      count_d = '0;
    end
  end

  // Phase the lamps will show after the coming edge, so the caller can register it.
  assign phase = enable && (count_d < Half);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Exterior indicator FSM with flash timing, plus independent interior dome-light control.
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter int unsigned BLINK_HALF = DefaultBlinkHalf,
  parameter int unsigned DOME_HOLD  = DefaultDomeHold
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       key,
  input  logic [0:3] door,
  input  logic [1:0] int_mode,
  output logic [1:0] ext_state,
  output logic       light_left,
  output logic       light_right,
  output logic       light_int
);

  localparam logic [7:0] HoldLoad = 8'(DOME_HOLD);

  logic [1:0] state_q, state_d;
  logic       left_q, right_q, int_q, int_d;
  logic [7:0] hold_q, hold_d;
  logic       phase, active;

  assign state_d = ext_next(hazard_req, left_req, right_req);

  blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink_timer (
    .clk    (clk),
    .reset  (reset),
    .restart(state_d != state_q),
    .enable (state_d != ExtOff),
    .phase  (phase)
  );

  assign active = key | (|door);

  always_comb begin
    hold_d = '0;
    int_d  = 1'b0;
    case (int_mode)
      IntOn: int_d = 1'b1;
      IntDoor: begin
        if (active) begin
          hold_d = HoldLoad;
          int_d  = 1'b1;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 8'd1;
          int_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ExtOff;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      int_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      // Bit 1 marks LEFT/HAZARD, bit 0 marks RIGHT/HAZARD.
      left_q  <= phase & state_d[1];
      right_q <= phase & state_d[0];
      int_q   <= int_d;
      hold_q  <= hold_d;
    end
  end

  assign ext_state   = state_q;
  assign light_left  = left_q;
  assign light_right = right_q;
  assign light_int   = int_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with a cycle-level behavioural model and literal checks.
module tb_light_sequencer;

  localparam int BH  = 4;
  localparam int DH  = 8;
  localparam int BIG = 1000;

  logic       clk = 1'b0;
  logic       reset, left_req, right_req, hazard_req, key;
  logic [0:3] door;
  logic [1:0] int_mode;
  logic [1:0] ext_state;
  logic       light_left, light_right, light_int;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  light_sequencer #(
    .BLINK_HALF(BH),
    .DOME_HOLD (DH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .left_req   (left_req),
    .right_req  (right_req),
    .hazard_req (hazard_req),
    .key        (key),
    .door       (door),
    .int_mode   (int_mode),
    .ext_state  (ext_state),
    .light_left (light_left),
    .light_right(light_right),
    .light_int  (light_int)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: state age since last change gives the flash phase; cycles since the last
  // active door/key sample give the dome light.
  initial begin
    int  m_state, m_age, m_since, ns;
    bit  m_valid, on, e_left, e_right, e_int;
    m_state = 0; m_age = 0; m_since = BIG; m_valid = 0; e_int = 0;
    forever begin
      @(posedge clk);
      ns = hazard_req ? 3 : ((left_req ^ right_req) ? (left_req ? 2 : 1) : 0);
      if (reset) begin
        m_state = 0; m_age = 0; m_since = BIG; e_int = 0; m_valid = 1;
      end else begin
        m_age   = (ns != m_state) ? 0 : m_age + 1;
        m_state = ns;
        case (int_mode)
          2'b00: begin e_int = 1; m_since = BIG; end
          2'b01: begin
            if (key || door != 4'b0) m_since = 0;
            else if (m_since < BIG) m_since++;
            e_int = (m_since <= DH);
          end
          default: begin e_int = 0; m_since = BIG; end
        endcase
      end
      on      = (m_state != 0) && ((m_age % (2 * BH)) < BH);
      e_left  = on && (m_state == 2 || m_state == 3);
      e_right = on && (m_state == 1 || m_state == 3);
      #1;
      if (m_valid) begin
        check("model_ext_state", 32'(ext_state), 32'(m_state));
        check("model_light_left", 32'(light_left), 32'(e_left));
        check("model_light_right", 32'(light_right), 32'(e_right));
        check("model_light_int", 32'(light_int), 32'(e_int));
      end
    end
  end

  initial begin
    logic [15:0] pat16;
    logic [5:0]  pat6;
    logic [7:0]  pat8;
    reset = 1'b1; left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0;
    key = 1'b0; door = 4'b0; int_mode = 2'b10;
    repeat (2) @(negedge clk);
    check("reset_ext_state", 32'(ext_state), 32'd0);
    check("reset_lamps", 32'({light_left, light_right}), 32'd0);
    check("reset_int", 32'(light_int), 32'd0);
    reset = 1'b0;

    // Left stalk: 1111 0000 1111 0000
    left_req = 1'b1;
    pat16 = 16'b1111000011110000;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("left_blink", 32'(light_left), 32'(pat16[15-i]));
      check("left_right_off", 32'(light_right), 32'd0);
      check("left_state", 32'(ext_state), 32'd2);
    end

    // Hazard override and release back to LEFT with a fresh phase
    left_req = 1'b0;
    @(negedge clk);
    left_req = 1'b1;
    repeat (6) @(negedge clk);
    hazard_req = 1'b1;
    pat6 = 6'b111100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hazard_state", 32'(ext_state), 32'd3);
      check("hazard_lamps", 32'({light_left, light_right}), pat6[5-i] ? 32'd3 : 32'd0);
    end
    hazard_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("release_state", 32'(ext_state), 32'd2);
      check("release_lamps", 32'({light_left, light_right}), 32'd2);
    end

    // Both stalks cancel; right alone mirrors left
    right_req = 1'b1;
    @(negedge clk);
    check("both_state", 32'(ext_state), 32'd0);
    check("both_lamps", 32'({light_left, light_right}), 32'd0);
    left_req = 1'b0;
    @(negedge clk);
    check("right_state", 32'(ext_state), 32'd1);
    check("right_lamps", 32'({light_left, light_right}), 32'd1);
    right_req = 1'b0;

    // Door hold: 3 open cycles, then exactly 8 held cycles
    int_mode = 2'b01;
    @(negedge clk);
    check("door_idle", 32'(light_int), 32'd0);
    door[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("door_open", 32'(light_int), 32'd1);
    end
    door[2] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("door_hold", 32'(light_int), (i < 8) ? 32'd1 : 32'd0);
    end

    // Reopen at hold cycle 5 reloads the full hold
    door[2] = 1'b1;
    @(negedge clk);
    door[2] = 1'b0;
    repeat (5) @(negedge clk);
    door[2] = 1'b1;
    @(negedge clk);
    check("door_reopen", 32'(light_int), 32'd1);
    door[2] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("door_reload", 32'(light_int), (i < 8) ? 32'd1 : 32'd0);
    end

    // Key starts a hold; reset lands during HAZARD ON and mid-hold
    key = 1'b1;
    @(negedge clk);
    check("key_on", 32'(light_int), 32'd1);
    key = 1'b0;
    hazard_req = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_state", 32'(ext_state), 32'd0);
    check("midreset_lamps", 32'({light_left, light_right}), 32'd0);
    check("midreset_int", 32'(light_int), 32'd0);
    reset = 1'b0;
    pat8 = 8'b11110000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_reset_hazard", 32'({light_left, light_right}), pat8[7-i] ? 32'd3 : 32'd0);
      if (i == 0) check("post_reset_int", 32'(light_int), 32'd0);
    end
    hazard_req = 1'b0;

    // Mode sequence ON -> OFF -> DOOR with nothing open
    int_mode = 2'b00;
    @(negedge clk);
    check("mode_on", 32'(light_int), 32'd1);
    int_mode = 2'b10;
    @(negedge clk);
    check("mode_off", 32'(light_int), 32'd0);
    int_mode = 2'b01;
    @(negedge clk);
    check("mode_door_idle", 32'(light_int), 32'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
